ptpv2_ts_capture_mux: RTL and testbench
=======================================

// Module: ptpv2_ts_capture_mux
// PURPOSE
//  Multi-channel PTP event-timestamp collector for a ptpv2 endpoint with NCH MAC ports.
//  - Samples the RTC time on each per-channel rx/tx PTP event strobe.
//  - Round-robin arbitrates the captures into one DEPTH-entry FIFO, drained by software.
//  - Replaces the single-port int_rx_ptp/int_tx_ptp interrupt scheme with a threshold interrupt.
// PARAMETERS
//  NCH    4   number of MAC channels (1..16)
//  DEPTH  16  FIFO entries, power of 2 (>=2)
//  TS_W   80  timestamp width {48b sec, 32b ns}
//  SEQ_W  16  PTP sequenceId width
//  Derived: CH_W=max(1,clog2(NCH)), AW=clog2(DEPTH), E_W=CH_W+1+SEQ_W+TS_W
// PORTS
//  rtc_clk     in   1          RTC clock; all logic single-clock
//  rtc_rst     in   1          asynchronous reset, active-high
//  ch_en_i     in   NCH        per-channel capture enable
//  cap_vld_i   in   NCH        1-cycle event strobe per channel
//  cap_dir_i   in   NCH        0=rx, 1=tx; qualified by cap_vld_i
//  cap_seq_i   in   NCH*SEQ_W  sequenceId; channel k at [k*SEQ_W +: SEQ_W]
//  rtc_ts_i    in   TS_W       current RTC time
//  rd_req_i    in   1          pop head entry
//  int_thr_i   in   AW+1       interrupt threshold (0 = interrupt disabled)
//  ovf_clr_i   in   1          clear ovf_o (and drop_cnt_o)
//  rd_vld_o    out  1          FIFO non-empty
//  rd_data_o   out  E_W        head entry {ch, dir, seq, ts}, first-word-fall-through
//  fifo_cnt_o  out  AW+1       occupancy, 0..DEPTH
//  int_ts_o    out  1          level: int_thr_i!=0 && fifo_cnt_o>=int_thr_i
//  ovf_o       out  NCH        sticky per-channel capture-drop flag
//  drop_cnt_o  out  NCH*8      per-channel drop counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO pointers 0; all pending slots empty; RR pointer 0.
//  Capture:
//   - Each channel has a 1-entry pending slot {dir, seq, ts}.
//   - cap_vld_i[k] & ch_en_i[k] in cycle N loads the slot with rtc_ts_i sampled in cycle N.
//   - ch_en_i low masks new strobes only; an already-pending entry is still delivered.
//  Drop:
//   - Strobe arrives while slot k is full and slot k is not granted in that cycle:
//     new event is discarded, old entry is kept, ovf_o[k] is set.
//   - Slot k granted in the same cycle as a new strobe: the new strobe refills the slot; no drop.
//  Arbitration:
//   - Grants at most one pending slot per cycle, and only when fifo_cnt_o<DEPTH.
//   - Grant decision uses the registered count; a same-cycle pop does not free a slot for a grant.
//   - Round-robin search starts at rr_ptr; after a grant to channel g, rr_ptr=(g+1)%NCH.
//   - Nothing granted: rr_ptr unchanged.
//  FIFO:
//   - Granted entry is written at the end of the cycle.
//   - Latency: strobe in N -> earliest write in N+1 -> rd_vld_o/rd_data_o valid in N+2.
//   - rd_req_i & rd_vld_o pops the head; rd_data_o shows the next entry in the following cycle.
//   - rd_req_i while empty is ignored.
//   - Same-cycle push and pop leave the count unchanged.
//   - Read/write pointers wrap modulo DEPTH.
//  Clear: ovf_clr_i clears ovf_o; a same-cycle drop wins, so that flag stays set.
//  Reset mid-operation: all entries and pending slots are lost; outputs return to reset values.
// CONFIGURATION
//  Macro PTPV2_TS_DROP_CNT_EN
//   defined:
//    - drop_cnt_o[k*8 +: 8] counts drops on channel k and saturates at 255.
//    - ovf_clr_i zeroes the counter; a same-cycle drop leaves it at 1.
//   undefined:
//    - no counters are synthesized; drop_cnt_o is tied to 0.
//    - ovf_o behaves identically in both builds.
// TESTING
//  T1 Latency: one strobe ch2 dir=1 seq=0x1234, rtc_ts=T
//     -> rd_vld 2 cycles later with data {2,1,0x1234,T}; pop -> cnt=0.
//  T2 Fairness: all 4 channels strobe in one cycle, rr_ptr=0
//     -> FIFO order ch0,1,2,3 over 4 cycles; repeat -> order ch0,1,2,3 again (rr_ptr back to 0).
//  T3 Full: DEPTH=16, no reads, 17 strobes on ch0
//     -> cnt=16, slot full; 18th strobe sets ovf_o[0]=1; drop_cnt[0]=1 if macro defined.
//  T4 Refill race: ch1 strobe in the same cycle slot1 is granted
//     -> both events reach the FIFO, ovf_o=0.
//  T5 Interrupt: int_thr=3
//     -> int_ts_o rises when cnt goes 2->3 and falls on the pop back to 2; int_thr=0 -> never asserts.
//  T6 Reset: assert rtc_rst with cnt=5 and slots pending
//     -> cnt=0, rd_vld=0, ovf=0 asynchronously; no stale entry after release.

Source files
------------

// File: rtl/ptpv2_ts_capture_mux.sv
// ptpv2_ts_capture_mux
// Multi-channel PTP event-timestamp collector. Each MAC channel owns a
// one-entry pending slot that latches {dir, seq, rtc_ts} on its event strobe;
// a round-robin arbiter moves at most one pending slot per cycle into a
// first-word-fall-through FIFO that software drains. A level interrupt fires
// when occupancy reaches a programmable threshold.
// Optional build macro: PTPV2_TS_DROP_CNT_EN adds saturating per-channel
// drop counters on drop_cnt_o; without it drop_cnt_o is tied to zero.
module ptpv2_ts_capture_mux #(
    parameter  int NCH   = 4,
    parameter  int DEPTH = 16,
    parameter  int TS_W  = 80,
    parameter  int SEQ_W = 16,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int E_W   = CH_W + 1 + SEQ_W + TS_W
) (
    input  logic                 rtc_clk,
    input  logic                 rtc_rst,
    input  logic [NCH-1:0]       ch_en_i,
    input  logic [NCH-1:0]       cap_vld_i,
    input  logic [NCH-1:0]       cap_dir_i,
    input  logic [NCH*SEQ_W-1:0] cap_seq_i,
    input  logic [TS_W-1:0]      rtc_ts_i,
    input  logic                 rd_req_i,
    input  logic [AW:0]          int_thr_i,
    input  logic                 ovf_clr_i,
    output logic                 rd_vld_o,
    output logic [E_W-1:0]       rd_data_o,
    output logic [AW:0]          fifo_cnt_o,
    output logic                 int_ts_o,
    output logic [NCH-1:0]       ovf_o,
    output logic [NCH*8-1:0]     drop_cnt_o
);

    // ------------------------------------------------------------------
    // Pending slots
    // ------------------------------------------------------------------
    logic [NCH-1:0]   r_pend;
    logic [NCH-1:0]   r_sdir;
    logic [SEQ_W-1:0] r_sseq [NCH];
    logic [TS_W-1:0]  r_sts  [NCH];
    logic [NCH-1:0]   r_ovf;

    logic [NCH-1:0]   w_stb;
    logic [NCH-1:0]   w_gnt;
    logic [NCH-1:0]   w_drop;

    // ------------------------------------------------------------------
    // Arbiter / FIFO state
    // ------------------------------------------------------------------
    logic [CH_W-1:0]  r_rr;
    logic [E_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;

    logic             w_full;
    logic             w_gnt_vld;
    logic [CH_W-1:0]  w_gnt_idx;
    logic [CH_W:0]    w_rr_inc;
    logic [CH_W-1:0]  w_rr_nxt;
    logic [E_W-1:0]   w_entry;
    logic             w_push;
    logic             w_pop;

    assign w_stb  = cap_vld_i & ch_en_i;
    // Grant eligibility uses the registered count only, so a pop in the
    // same cycle never opens room for a grant.
    assign w_full = (r_cnt == (AW+1)'(DEPTH));

    // Round-robin search starting at r_rr; first pending slot wins.
    always_comb begin
        logic [CH_W:0] v_sum;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        v_sum     = '0;
        if (!w_full) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                v_sum = {1'b0, r_rr} + (CH_W+1)'(i);
                if (v_sum >= (CH_W+1)'(NCH)) begin
                    v_sum = v_sum - (CH_W+1)'(NCH);
                end
                if (!w_gnt_vld && r_pend[v_sum[CH_W-1:0]]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = v_sum[CH_W-1:0];
                end
            end
        end
    end

    // One-hot grant vector for the slot update logic.
    always_comb begin
        w_gnt = '0;
        if (w_gnt_vld) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign w_rr_inc = {1'b0, w_gnt_idx} + (CH_W+1)'(1);
    assign w_rr_nxt = (w_rr_inc >= (CH_W+1)'(NCH)) ? '0 : w_rr_inc[CH_W-1:0];

    assign w_entry  = {w_gnt_idx, r_sdir[w_gnt_idx], r_sseq[w_gnt_idx], r_sts[w_gnt_idx]};
    assign w_push   = w_gnt_vld;
    assign w_pop    = rd_req_i & (r_cnt != '0);

    // A strobe is dropped only when its slot stays occupied this cycle.
    assign w_drop   = w_stb & r_pend & ~w_gnt;

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_slot
            // Slot k: load on strobe when empty or being granted, free on grant.
            always_ff @(posedge rtc_clk or posedge rtc_rst) begin
                if (rtc_rst) begin
                    r_pend[k] <= 1'b0;
                    r_sdir[k] <= 1'b0;
                    r_sseq[k] <= '0;
                    r_sts[k]  <= '0;
                end else if (w_stb[k] && (!r_pend[k] || w_gnt[k])) begin
                    r_pend[k] <= 1'b1;
                    r_sdir[k] <= cap_dir_i[k];
                    r_sseq[k] <= cap_seq_i[k*SEQ_W +: SEQ_W];
                    r_sts[k]  <= rtc_ts_i;
                end else if (w_gnt[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end

            // Sticky overflow flag; a drop in the clear cycle keeps it set.
            always_ff @(posedge rtc_clk or posedge rtc_rst) begin
                if (rtc_rst) begin
                    r_ovf[k] <= 1'b0;
                end else if (w_drop[k]) begin
                    r_ovf[k] <= 1'b1;
                end else if (ovf_clr_i) begin
                    r_ovf[k] <= 1'b0;
                end
            end

`ifdef PTPV2_TS_DROP_CNT_EN
            logic [7:0] r_dcnt;

            // Saturating drop counter; clear with a same-cycle drop restarts at 1.
            always_ff @(posedge rtc_clk or posedge rtc_rst) begin
                if (rtc_rst) begin
                    r_dcnt <= '0;
                end else if (ovf_clr_i) begin
                    r_dcnt <= w_drop[k] ? 8'd1 : 8'd0;
                end else if (w_drop[k] && (r_dcnt != '1)) begin
                    r_dcnt <= r_dcnt + 8'd1;
                end
            end

            assign drop_cnt_o[k*8 +: 8] = r_dcnt;
`else
            assign drop_cnt_o[k*8 +: 8] = '0;
`endif
        end
    endgenerate

    // Round-robin pointer advances past the granted channel only.
    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            r_rr <= '0;
        end else if (w_gnt_vld) begin
            r_rr <= w_rr_nxt;
        end
    end

    // FIFO storage; contents are don't-care while outside the valid window.
    always_ff @(posedge rtc_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rd_vld_o   = (r_cnt != '0);
    assign rd_data_o  = rd_vld_o ? r_mem[r_rptr] : '0;
    assign fifo_cnt_o = r_cnt;
    assign int_ts_o   = (int_thr_i != '0) && (r_cnt >= int_thr_i);
    assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_ptpv2_ts_capture_mux.sv
// Scoreboard bench for ptpv2_ts_capture_mux: stimulus pushes expected FIFO
// entries into a queue, a negedge monitor pops and compares on every read.
module tb_ptpv2_ts_capture_mux;

    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int TS_W  = 80;
    localparam int SEQ_W = 16;
    localparam int CH_W  = 2;
    localparam int AW    = 4;
    localparam int E_W   = CH_W + 1 + SEQ_W + TS_W;

    logic                 rtc_clk = 1'b0;
    logic                 rtc_rst = 1'b1;
    logic [NCH-1:0]       ch_en_i = '1;
    logic [NCH-1:0]       cap_vld_i = '0;
    logic [NCH-1:0]       cap_dir_i = '0;
    logic [NCH*SEQ_W-1:0] cap_seq_i = '0;
    logic [TS_W-1:0]      rtc_ts_i = 80'h0000_6543_2100_1000_0000;
    logic                 rd_req_i = 1'b0;
    logic [AW:0]          int_thr_i = '0;
    logic                 ovf_clr_i = 1'b0;
    logic                 rd_vld_o;
    logic [E_W-1:0]       rd_data_o;
    logic [AW:0]          fifo_cnt_o;
    logic                 int_ts_o;
    logic [NCH-1:0]       ovf_o;
    logic [NCH*8-1:0]     drop_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [E_W-1:0] exp_q[$];

`ifdef PTPV2_TS_DROP_CNT_EN
    localparam logic [31:0] DCNT_ONE = 32'h0000_0001;
`else
    localparam logic [31:0] DCNT_ONE = 32'h0000_0000;
`endif

    ptpv2_ts_capture_mux #(
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .TS_W  (TS_W),
        .SEQ_W (SEQ_W)
    ) dut (
        .rtc_clk    (rtc_clk),
        .rtc_rst    (rtc_rst),
        .ch_en_i    (ch_en_i),
        .cap_vld_i  (cap_vld_i),
        .cap_dir_i  (cap_dir_i),
        .cap_seq_i  (cap_seq_i),
        .rtc_ts_i   (rtc_ts_i),
        .rd_req_i   (rd_req_i),
        .int_thr_i  (int_thr_i),
        .ovf_clr_i  (ovf_clr_i),
        .rd_vld_o   (rd_vld_o),
        .rd_data_o  (rd_data_o),
        .fifo_cnt_o (fifo_cnt_o),
        .int_ts_o   (int_ts_o),
        .ovf_o      (ovf_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 rtc_clk = ~rtc_clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; the RTC moves every cycle.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge rtc_clk);
            #1;
            rtc_ts_i = rtc_ts_i + 80'h0000_0000_0001_0000_0007;
        end
    endtask

    // Raise a strobe for the current cycle; optionally expect it in the FIFO.
    task automatic strobe(input int ch, input bit dir, input logic [SEQ_W-1:0] seq, input bit expect_it);
        cap_vld_i[ch] = 1'b1;
        cap_dir_i[ch] = dir;
        cap_seq_i[ch*SEQ_W +: SEQ_W] = seq;
        if (expect_it) begin
            exp_q.push_back({CH_W'(ch), dir, seq, rtc_ts_i});
        end
    endtask

    task automatic clr_strobes();
        cap_vld_i = '0;
        cap_dir_i = '0;
    endtask

    task automatic do_reset();
        chk("queue_drained_before_reset", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        rtc_rst   = 1'b1;
        clr_strobes();
        rd_req_i  = 1'b0;
        ovf_clr_i = 1'b0;
        int_thr_i = '0;
        ch_en_i   = '1;
        tick(2);
        rtc_rst = 1'b0;
        tick(1);
        chk("rst_rd_vld", 128'(rd_vld_o), 128'd0);
        chk("rst_cnt", 128'(fifo_cnt_o), 128'd0);
        chk("rst_data", 128'(rd_data_o), 128'd0);
        chk("rst_ovf", 128'(ovf_o), 128'd0);
        chk("rst_int", 128'(int_ts_o), 128'd0);
        chk("rst_dcnt", 128'(drop_cnt_o), 128'd0);
    endtask

    // Monitor: every accepted read is compared against the scoreboard head.
    always @(negedge rtc_clk) begin
        if (!rtc_rst && rd_vld_o && rd_req_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected: got=%0h exp=none at %0t", rd_data_o, $time);
            end else begin
                logic [E_W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data_o !== e) begin
                    errors++;
                    $display("FAIL mon_data: got=%0h exp=%0h at %0t", rd_data_o, e, $time);
                end
            end
        end
    end

    initial begin
        tick(1);
        do_reset();

        // T2 fairness: all four channels in one cycle, twice.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NCH; c++) begin
                strobe(c, c[0], 16'h0100 + 16'(r*16 + c), 1'b1);
            end
            tick(1);
            clr_strobes();
            tick(4);
            chk("t2_cnt", 128'(fifo_cnt_o), 128'(4*(r+1)));
        end
        rd_req_i = 1'b1;
        tick(8);
        rd_req_i = 1'b0;
        chk("t2_drained", 128'(fifo_cnt_o), 128'd0);

        // T1 latency: ch2 tx seq 0x1234.
        do_reset();
        strobe(2, 1'b1, 16'h1234, 1'b1);
        tick(1);
        clr_strobes();
        chk("t1_vld_n1", 128'(rd_vld_o), 128'd0);
        tick(1);
        chk("t1_vld_n2", 128'(rd_vld_o), 128'd1);
        chk("t1_cnt_n2", 128'(fifo_cnt_o), 128'd1);
        rd_req_i = 1'b1;
        tick(1);
        rd_req_i = 1'b0;
        chk("t1_cnt_pop", 128'(fifo_cnt_o), 128'd0);
        chk("t1_vld_pop", 128'(rd_vld_o), 128'd0);

        // T3 full: 17 strobes fill FIFO plus slot, 18th drops.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            clr_strobes();
            strobe(0, i[0], 16'h3000 + 16'(i), 1'b1);
            tick(1);
        end
        clr_strobes();
        chk("t3_cnt_full", 128'(fifo_cnt_o), 128'd16);
        chk("t3_ovf_before", 128'(ovf_o), 128'd0);
        strobe(0, 1'b1, 16'h3FFF, 1'b0);
        tick(1);
        clr_strobes();
        chk("t3_ovf_drop", 128'(ovf_o), 128'b0001);
        chk("t3_dcnt_drop", 128'(drop_cnt_o), 128'(DCNT_ONE));
        chk("t3_cnt_still", 128'(fifo_cnt_o), 128'd16);
        // clear and drop in the same cycle: the drop wins
        ovf_clr_i = 1'b1;
        strobe(0, 1'b0, 16'h3FFE, 1'b0);
        tick(1);
        clr_strobes();
        ovf_clr_i = 1'b0;
        chk("t3_ovf_clr_race", 128'(ovf_o), 128'b0001);
        chk("t3_dcnt_clr_race", 128'(drop_cnt_o), 128'(DCNT_ONE));
        ovf_clr_i = 1'b1;
        tick(1);
        ovf_clr_i = 1'b0;
        chk("t3_ovf_clr", 128'(ovf_o), 128'd0);
        chk("t3_dcnt_clr", 128'(drop_cnt_o), 128'd0);
        rd_req_i = 1'b1;
        tick(20);
        rd_req_i = 1'b0;
        chk("t3_drained", 128'(fifo_cnt_o), 128'd0);

        // T4 refill race plus channel-enable masking.
        do_reset();
        strobe(1, 1'b0, 16'h4001, 1'b1);
        tick(1);
        clr_strobes();
        strobe(1, 1'b1, 16'h4002, 1'b1);
        tick(1);
        clr_strobes();
        tick(3);
        chk("t4_ovf", 128'(ovf_o), 128'd0);
        chk("t4_cnt", 128'(fifo_cnt_o), 128'd2);
        ch_en_i = 4'b0111;
        strobe(3, 1'b1, 16'h4003, 1'b0);
        tick(1);
        clr_strobes();
        ch_en_i = '1;
        tick(3);
        chk("t4_masked_cnt", 128'(fifo_cnt_o), 128'd2);
        rd_req_i = 1'b1;
        tick(3);
        rd_req_i = 1'b0;
        chk("t4_drained", 128'(fifo_cnt_o), 128'd0);

        // T5 threshold interrupt.
        do_reset();
        int_thr_i = 5'd3;
        strobe(0, 1'b0, 16'h5000, 1'b1);
        tick(1);
        clr_strobes();
        strobe(0, 1'b1, 16'h5001, 1'b1);
        tick(1);
        clr_strobes();
        chk("t5_cnt1_int", 128'(int_ts_o), 128'd0);
        strobe(0, 1'b0, 16'h5002, 1'b1);
        tick(1);
        clr_strobes();
        chk("t5_cnt2", 128'(fifo_cnt_o), 128'd2);
        chk("t5_cnt2_int", 128'(int_ts_o), 128'd0);
        tick(1);
        chk("t5_cnt3", 128'(fifo_cnt_o), 128'd3);
        chk("t5_cnt3_int", 128'(int_ts_o), 128'd1);
        rd_req_i = 1'b1;
        tick(1);
        rd_req_i = 1'b0;
        chk("t5_pop_cnt", 128'(fifo_cnt_o), 128'd2);
        chk("t5_pop_int", 128'(int_ts_o), 128'd0);
        int_thr_i = 5'd0;
        #1;
        chk("t5_thr0_int", 128'(int_ts_o), 128'd0);
        int_thr_i = 5'd2;
        #1;
        chk("t5_thr2_int", 128'(int_ts_o), 128'd1);
        int_thr_i = 5'd0;
        rd_req_i = 1'b1;
        tick(2);
        rd_req_i = 1'b0;
        chk("t5_drained", 128'(fifo_cnt_o), 128'd0);

        // T6 asynchronous reset with entries, pending slots and a drop.
        do_reset();
        for (int c = 0; c < NCH; c++) strobe(c, 1'b0, 16'h6000 + 16'(c), 1'b0);
        tick(1);
        clr_strobes();
        tick(4);
        chk("t6_cnt4", 128'(fifo_cnt_o), 128'd4);
        for (int c = 0; c < NCH; c++) strobe(c, 1'b1, 16'h6010 + 16'(c), 1'b0);
        tick(1);
        clr_strobes();
        strobe(3, 1'b0, 16'h60FF, 1'b0);
        tick(1);
        clr_strobes();
        chk("t6_cnt5", 128'(fifo_cnt_o), 128'd5);
        chk("t6_ovf_pre", 128'(ovf_o), 128'b1000);
        #2;
        rtc_rst = 1'b1;
        #1;
        chk("t6_async_cnt", 128'(fifo_cnt_o), 128'd0);
        chk("t6_async_vld", 128'(rd_vld_o), 128'd0);
        chk("t6_async_ovf", 128'(ovf_o), 128'd0);
        tick(2);
        rtc_rst = 1'b0;
        tick(5);
        chk("t6_post_cnt", 128'(fifo_cnt_o), 128'd0);
        chk("t6_post_vld", 128'(rd_vld_o), 128'd0);

        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
